// File: rtl/yarvi_fe_ctl_if.sv
// Store, loader, code-memory write and fetch-restart signals of the fetch controller.
// master = execute/loader/fetch side, slave = yarvi_fe_ctl.
interface yarvi_fe_ctl_if #(
  parameter int VMSB = 31,
  parameter int CNTW = 16
);
  logic            st_valid;
  logic            st_ready;
  logic [VMSB:0]   st_addr;
  logic [31:0]     st_data;
  logic [3:0]      st_mask;
  logic [VMSB:0]   st_resume_pc;

  logic            ld_session;
  logic            ld_valid;
  logic            ld_ready;
  logic [VMSB:0]   ld_addr;
  logic [31:0]     ld_data;
  logic [3:0]      ld_mask;
  logic [CNTW-1:0] ld_count;

  logic [VMSB:0]   mem_address;
  logic [31:0]     mem_writedata;
  logic [3:0]      mem_writemask;
  logic            fe_restart;
  logic [VMSB:0]   fe_restart_pc;

  modport master (
    output st_valid, st_addr, st_data, st_mask, st_resume_pc,
    output ld_session, ld_valid, ld_addr, ld_data, ld_mask,
    input  st_ready, ld_ready, ld_count,
    input  mem_address, mem_writedata, mem_writemask, fe_restart, fe_restart_pc
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_mask, st_resume_pc,
    input  ld_session, ld_valid, ld_addr, ld_data, ld_mask,
    output st_ready, ld_ready, ld_count,
    output mem_address, mem_writedata, mem_writemask, fe_restart, fe_restart_pc
  );
endinterface

// File: rtl/yarvi_fe_ctl.sv
// Fetch-stage sequencer: arbitrates the code-memory write port between core stores and
// the loader, and restarts fetch after reset, code-window stores and load sessions.
module yarvi_fe_ctl #(
   parameter int VMSB      = 31,
   parameter int PMSB      = 13,
   parameter int CODE_BASE = 0,
   parameter int CNTW      = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [VMSB:0]   boot_pc,
   yarvi_fe_ctl_if.slave   bus
);

   localparam int TAGW = VMSB - PMSB;
   localparam logic [TAGW-1:0] CODE_TAG = TAGW'(CODE_BASE);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_LOAD} state_e;

   state_e          state_q, state_d;
   logic [VMSB:0]   saved_pc_q, saved_pc_d;
   logic [VMSB:0]   mem_addr_q, mem_addr_d;
   logic [31:0]     mem_data_q, mem_data_d;
   logic [3:0]      mem_mask_q, mem_mask_d;
   logic [CNTW-1:0] ld_count_q, ld_count_d;

   logic st_fire, ld_fire, st_in_win, ld_in_win;

   assign st_fire   = bus.st_valid & bus.st_ready;
   assign ld_fire   = bus.ld_valid & bus.ld_ready;
   assign st_in_win = (bus.st_addr[VMSB:PMSB+1] == CODE_TAG);
   assign ld_in_win = (bus.ld_addr[VMSB:PMSB+1] == CODE_TAG);

   always_comb begin
      // NOTE: every variable gets its default before the case so no path infers a latch.
      state_d    = state_q;
      saved_pc_d = saved_pc_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_mask_d = '0;
      ld_count_d = ld_count_q;

      case (state_q)
         ST_RUN: begin
            if (bus.ld_session) begin
               state_d    = ST_LOAD;
               ld_count_d = '0;
            end else if (st_fire && st_in_win) begin
               mem_addr_d = bus.st_addr;
               mem_data_d = bus.st_data;
               mem_mask_d = bus.st_mask;
               saved_pc_d = bus.st_resume_pc;
               state_d    = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (bus.ld_session) begin
               state_d    = ST_LOAD;
               ld_count_d = '0;
            end else begin
               state_d    = ST_RUN;
            end
         end
         ST_LOAD: begin
            if (ld_fire) begin
               ld_count_d = CNTW'(ld_count_q + 1'b1);
               if (ld_in_win) begin
                  mem_addr_d = bus.ld_addr;
                  mem_data_d = bus.ld_data;
                  mem_mask_d = bus.ld_mask;
               end
            end
            // A write accepted in the closing cycle still lands, during the FLUSH.
            if (!bus.ld_session) begin
               saved_pc_d = boot_pc;
               state_d    = ST_FLUSH;
            end
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   // NOTE: saved_pc tracks boot_pc while reset is held, so it reloads on every clock in reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: state registers use non-blocking assignment so all of them update together.
         state_q    <= ST_FLUSH;
         saved_pc_q <= boot_pc;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_mask_q <= '0;
         ld_count_q <= '0;
      end else begin
         state_q    <= state_d;
         saved_pc_q <= saved_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_mask_q <= mem_mask_d;
         ld_count_q <= ld_count_d;
      end
   end

   assign bus.st_ready      = (state_q == ST_RUN) & ~bus.ld_session;
   assign bus.ld_ready      = (state_q == ST_LOAD);
   assign bus.ld_count      = ld_count_q;
   assign bus.mem_address   = mem_addr_q;
   assign bus.mem_writedata = mem_data_q;
   assign bus.mem_writemask = mem_mask_q;
   assign bus.fe_restart    = (state_q != ST_RUN);
   assign bus.fe_restart_pc = (state_q == ST_LOAD) ? boot_pc : saved_pc_q;

endmodule

// File: tb/tb_yarvi_fe_ctl.sv
// Directed bench for yarvi_fe_ctl: expected code-memory writes are queued when driven
// and matched against every nonzero mem_writemask pulse.
module tb_yarvi_fe_ctl;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] boot_pc;
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          mon_en   = 1'b0;
   wr_t         exp_q[$];

   yarvi_fe_ctl_if #(.VMSB(31), .CNTW(16)) bus ();

   yarvi_fe_ctl #(.VMSB(31), .PMSB(13), .CODE_BASE(0), .CNTW(16)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .boot_pc (boot_pc),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.mask = m;
      exp_q.push_back(w);
   endtask

   task automatic drain(input string tag);
      @(negedge clock);
      #1;
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard: every write pulse must match the oldest expected write.
   always @(negedge clock) begin
      if (mon_en && bus.mem_writemask !== 4'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(bus.mem_writemask), 64'd0);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("wr_addr", 64'(bus.mem_address),   64'(w.addr));
            check("wr_data", 64'(bus.mem_writedata), 64'(w.data));
            check("wr_mask", 64'(bus.mem_writemask), 64'(w.mask));
         end
      end
   end

   initial begin
      reset_n          = 1'b0;
      boot_pc          = 32'h100;
      bus.st_valid     = 1'b0;
      bus.st_addr      = '0;
      bus.st_data      = '0;
      bus.st_mask      = '0;
      bus.st_resume_pc = '0;
      bus.ld_session   = 1'b0;
      bus.ld_valid     = 1'b0;
      bus.ld_addr      = '0;
      bus.ld_data      = '0;
      bus.ld_mask      = '0;

      // 1: reset values, then a single FLUSH cycle at boot_pc
      step();
      step();
      mon_en = 1'b1;
      check("rst_restart",  64'(bus.fe_restart),    64'd1);
      check("rst_pc",       64'(bus.fe_restart_pc), 64'h100);
      check("rst_mask",     64'(bus.mem_writemask), 64'd0);
      check("rst_addr",     64'(bus.mem_address),   64'd0);
      check("rst_data",     64'(bus.mem_writedata), 64'd0);
      check("rst_count",    64'(bus.ld_count),      64'd0);
      check("rst_st_ready", 64'(bus.st_ready),      64'd0);
      reset_n = 1'b1;
      #1;
      check("boot_restart", 64'(bus.fe_restart),    64'd1);
      check("boot_pc",      64'(bus.fe_restart_pc), 64'h100);
      step();
      check("run_restart",  64'(bus.fe_restart),    64'd0);
      check("run_st_ready", 64'(bus.st_ready),      64'd1);

      // 2: code-window store, back-to-back store stalled one cycle
      bus.st_valid     = 1'b1;
      bus.st_addr      = 32'h40;
      bus.st_data      = 32'hDEADBEEF;
      bus.st_mask      = 4'hF;
      bus.st_resume_pc = 32'h24;
      push_wr(32'h40, 32'hDEADBEEF, 4'hF);
      step();
      check("st_flush_restart", 64'(bus.fe_restart),    64'd1);
      check("st_flush_pc",      64'(bus.fe_restart_pc), 64'h24);
      check("st_flush_mask",    64'(bus.mem_writemask), 64'hF);
      check("st_flush_ready",   64'(bus.st_ready),      64'd0);
      bus.st_addr      = 32'h44;
      bus.st_data      = 32'h11112222;
      bus.st_mask      = 4'h3;
      bus.st_resume_pc = 32'h28;
      step();
      check("st2_restart", 64'(bus.fe_restart),    64'd0);
      check("st2_ready",   64'(bus.st_ready),      64'd1);
      check("st2_nomask",  64'(bus.mem_writemask), 64'd0);
      push_wr(32'h44, 32'h11112222, 4'h3);
      step();
      check("st2_flush_pc", 64'(bus.fe_restart_pc), 64'h28);
      bus.st_valid = 1'b0;
      step();
      check("st2_run", 64'(bus.fe_restart), 64'd0);

      // 3: store outside the code window is dropped without restart
      bus.st_valid     = 1'b1;
      bus.st_addr      = 32'h0000_4010;
      bus.st_data      = 32'h55AA55AA;
      bus.st_mask      = 4'hF;
      bus.st_resume_pc = 32'h60;
      step();
      check("data_mask",    64'(bus.mem_writemask), 64'd0);
      check("data_restart", 64'(bus.fe_restart),    64'd0);
      check("data_ready",   64'(bus.st_ready),      64'd1);
      bus.st_valid = 1'b0;
      step();

      // 4: load session with five writes
      bus.ld_session = 1'b1;
      #1;
      check("ld_st_ready", 64'(bus.st_ready), 64'd0);
      step();
      check("ld_restart", 64'(bus.fe_restart),    64'd1);
      check("ld_pc",      64'(bus.fe_restart_pc), 64'h100);
      check("ld_ready",   64'(bus.ld_ready),      64'd1);
      for (int i = 0; i < 5; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_addr  = 32'(i * 4);
         bus.ld_data  = $urandom;
         bus.ld_mask  = 4'hF;
         push_wr(bus.ld_addr, bus.ld_data, 4'hF);
         step();
         check($sformatf("ld_count_%0d", i), 64'(bus.ld_count), 64'(i + 1));
      end
      bus.ld_valid = 1'b0;
      drain("ld_drain");
      bus.ld_session = 1'b0;
      step();
      check("ldend_restart", 64'(bus.fe_restart),    64'd1);
      check("ldend_pc",      64'(bus.fe_restart_pc), 64'h100);
      check("ldend_count",   64'(bus.ld_count),      64'd5);
      step();
      check("ldend_run",   64'(bus.fe_restart), 64'd0);
      check("ldend_ready", 64'(bus.st_ready),   64'd1);

      // 5: store and session rise together; counter wraps; store lands afterwards
      bus.st_valid     = 1'b1;
      bus.st_addr      = 32'h80;
      bus.st_data      = 32'hA5A5_0F0F;
      bus.st_mask      = 4'hC;
      bus.st_resume_pc = 32'h30;
      bus.ld_session   = 1'b1;
      #1;
      check("col_st_ready", 64'(bus.st_ready), 64'd0);
      step();
      check("col_load",  64'(bus.ld_ready),      64'd1);
      check("col_count", 64'(bus.ld_count),      64'd0);
      check("col_mask",  64'(bus.mem_writemask), 64'd0);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h0000_4000;
      bus.ld_data  = 32'h0BAD_F00D;
      bus.ld_mask  = 4'hF;
      repeat (65535) step();
      check("wrap_ffff",    64'(bus.ld_count),      64'hFFFF);
      check("wrap_nomask",  64'(bus.mem_writemask), 64'd0);
      step();
      check("wrap_zero", 64'(bus.ld_count), 64'd0);
      bus.ld_valid   = 1'b0;
      bus.ld_session = 1'b0;
      step();
      check("col_flush",    64'(bus.fe_restart), 64'd1);
      check("col_flush_rd", 64'(bus.st_ready),   64'd0);
      step();
      check("col_run_rd", 64'(bus.st_ready), 64'd1);
      push_wr(32'h80, 32'hA5A5_0F0F, 4'hC);
      step();
      check("col_st_pc", 64'(bus.fe_restart_pc), 64'h30);
      bus.st_valid = 1'b0;
      step();
      drain("col_drain");

      // 6: asynchronous reset in the middle of a load session
      bus.ld_session = 1'b1;
      step();
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h8;
      bus.ld_data  = 32'hCAFEF00D;
      bus.ld_mask  = 4'h3;
      step();
      bus.ld_valid = 1'b0;
      check("ar_pre_count", 64'(bus.ld_count),      64'd1);
      check("ar_pre_mask",  64'(bus.mem_writemask), 64'h3);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("ar_mask",     64'(bus.mem_writemask), 64'd0);
      check("ar_count",    64'(bus.ld_count),      64'd0);
      check("ar_restart",  64'(bus.fe_restart),    64'd1);
      check("ar_pc",       64'(bus.fe_restart_pc), 64'h100);
      check("ar_ld_ready", 64'(bus.ld_ready),      64'd0);
      step();
      reset_n = 1'b1;
      #1;
      check("ar_flush", 64'(bus.ld_ready), 64'd0);
      step();
      check("ar_load",    64'(bus.ld_ready),      64'd1);
      check("ar_load_pc", 64'(bus.fe_restart_pc), 64'h100);
      bus.ld_session = 1'b0;
      step();
      step();
      check("ar_run", 64'(bus.fe_restart), 64'd0);
      drain("final_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
